// File: rtl/mmio_resp_if.sv
// rtl/mmio_resp_if.sv - CPU data-bus signal bundle between the bus initiator and the mmio responder
interface mmio_resp_if;
  logic        ce;
  logic        we;
  logic [31:0] addr_in;
  logic [3:0]  sel;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output ce, we, addr_in, sel, data_i,
    input  data_o
  );

  modport slave (
    input  ce, we, addr_in, sel, data_i,
    output data_o
  );
endinterface

// File: rtl/mmio_resp.sv
// rtl/mmio_resp.sv - memory-mapped responder: display word, debounced switches/buttons, edge capture irq, cycle counter
module mmio_resp #(
  parameter logic [31:0] BASE      = 32'hFFFF_0000,
  parameter int          DB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  mmio_resp_if.slave   bus,
  input  logic [15:0]  sw_i,
  input  logic [3:0]   btn_i,
  output logic [31:0]  seg_data_o,
  output logic         irq_o
);

  localparam int NB = 20;
  localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  localparam logic [2:0] IDX_SEG  = 3'd0;
  localparam logic [2:0] IDX_SW   = 3'd1;
  localparam logic [2:0] IDX_CAP  = 3'd2;
  localparam logic [2:0] IDX_MASK = 3'd3;
  localparam logic [2:0] IDX_CNT  = 3'd4;

  logic [31:0]   r_seg;
  logic [3:0]    r_mask;
  logic [3:0]    r_cap;
  logic [31:0]   r_cnt;
  logic          r_irq;
  logic [NB-1:0] r_sync1;
  logic [NB-1:0] r_sync2;
  logic [NB-1:0] r_stable;
  logic [CW-1:0] r_db_cnt [NB];
  logic [3:0]    r_btn_prev;

  logic          w_hit;
  logic          w_wr;
  logic [2:0]    w_idx;
  logic [31:0]   w_bmask;
  logic [3:0]    w_rise;
  logic [3:0]    w_cap_clr;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_unused  = &{1'b0, bus.addr_in[1:0]};
  assign w_hit     = bus.ce && (bus.addr_in[31:5] == BASE[31:5]);
  assign w_wr      = w_hit && bus.we;
  assign w_idx     = bus.addr_in[4:2];
  assign w_bmask   = {{8{bus.sel[3]}}, {8{bus.sel[2]}}, {8{bus.sel[1]}}, {8{bus.sel[0]}}};
  assign w_rise    = r_stable[19:16] & ~r_btn_prev;
  assign w_cap_clr = (w_wr && w_idx == IDX_CAP) ? (bus.data_i[3:0] & w_bmask[3:0]) : 4'h0;

  assign seg_data_o = r_seg;
  assign irq_o      = r_irq;
  assign bus.data_o = w_rdata;

  always_comb begin
    w_rdata = 32'h0;
    if (w_hit && !bus.we) begin
      case (w_idx)
        IDX_SEG:  w_rdata = r_seg;
        IDX_SW:   w_rdata = {16'h0, r_stable[15:0]};
        IDX_CAP:  w_rdata = {28'h0, r_cap};
        IDX_MASK: w_rdata = {28'h0, r_mask};
        IDX_CNT:  w_rdata = r_cnt;
        default:  w_rdata = 32'h0;
      endcase
    end
  end

  // Switches occupy bits [15:0] and buttons [19:16] of the shared input path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_btn_prev <= '0;
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1    <= {btn_i, sw_i};
      r_sync2    <= r_sync1;
      r_btn_prev <= r_stable[19:16];
      for (int i = 0; i < NB; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg  <= '0;
      r_mask <= '0;
      r_cap  <= '0;
      r_cnt  <= '0;
      r_irq  <= 1'b0;
    end else begin
      if (w_wr && w_idx == IDX_SEG)
        r_seg <= (r_seg & ~w_bmask) | (bus.data_i & w_bmask);
      if (w_wr && w_idx == IDX_MASK)
        r_mask <= (r_mask & ~w_bmask[3:0]) | (bus.data_i[3:0] & w_bmask[3:0]);
      // A capture set on the same edge as its W1C clear takes priority.
      r_cap <= (r_cap & ~w_cap_clr) | w_rise;
      if (w_wr && w_idx == IDX_CNT)
        r_cnt <= (r_cnt & ~w_bmask) | (bus.data_i & w_bmask);
      else
        r_cnt <= r_cnt + 32'd1;
      r_irq <= |(r_cap & r_mask);
    end
  end

endmodule

// File: tb/tb_mmio_resp.sv
// tb/tb_mmio_resp.sv - directed self-checking bench for mmio_resp
module tb_mmio_resp;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw_i;
  logic [3:0]  btn_i;
  logic [31:0] seg_data_o;
  logic        irq_o;
  int          n_cmp;
  int          n_err;

  localparam logic [31:0] A_SEG  = 32'hFFFF_0000;
  localparam logic [31:0] A_SW   = 32'hFFFF_0004;
  localparam logic [31:0] A_CAP  = 32'hFFFF_0008;
  localparam logic [31:0] A_MASK = 32'hFFFF_000C;
  localparam logic [31:0] A_CNT  = 32'hFFFF_0010;

  mmio_resp_if bus ();

  mmio_resp #(.BASE(32'hFFFF_0000), .DB_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst_n),
    .bus        (bus),
    .sw_i       (sw_i),
    .btn_i      (btn_i),
    .seg_data_o (seg_data_o),
    .irq_o      (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr_in = a; bus.sel = s; bus.data_i = d;
    @(posedge clk);
    #1;
    bus.ce = 1'b0; bus.we = 1'b0; bus.sel = 4'h0; bus.data_i = 32'h0;
  endtask

  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr_in = a;
    #1;
    check(tag, bus.data_o, exp);
    bus.ce = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; sw_i = '0; btn_i = '0;
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr_in = '0; bus.sel = '0; bus.data_i = '0;
    step(3);
    check("rst_seg_out", seg_data_o, 32'h0);
    check("rst_irq", {31'h0, irq_o}, 32'h0);
    check("rst_data_o", bus.data_o, 32'h0);
    rst_n = 1'b1;
    step(1);

    bus_write(A_SEG, 4'hF, 32'hAABB_CCDD);
    check("seg_full", seg_data_o, 32'hAABB_CCDD);
    rst_n = 1'b0;
    #1;
    check("midrst_seg_out", seg_data_o, 32'h0);
    bus_read("midrst_seg_rd", A_SEG, 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);

    bus_write(A_SEG, 4'b0011, 32'h1234_5678);
    check("seg_partial_out", seg_data_o, 32'h0000_5678);
    bus_read("seg_partial_rd", A_SEG, 32'h0000_5678);

    for (int i = 0; i < 10; i++) begin
      sw_i[3] = ~sw_i[3];
      step(1);
    end
    sw_i[3] = 1'b0;
    step(20);
    bus_read("sw_glitch", A_SW, 32'h0);
    sw_i[3] = 1'b1;
    step(17);
    bus_read("sw_17cyc", A_SW, 32'h0);
    step(1);
    bus_read("sw_18cyc", A_SW, 32'h0000_0008);

    bus_write(A_MASK, 4'hF, 32'h0000_0002);
    bus_read("mask_rd", A_MASK, 32'h2);
    btn_i[1] = 1'b1;
    step(18);
    bus_read("cap_before", A_CAP, 32'h0);
    step(1);
    bus_read("cap_set", A_CAP, 32'h2);
    check("irq_lag", {31'h0, irq_o}, 32'h0);
    step(1);
    check("irq_set", {31'h0, irq_o}, 32'h1);

    bus_write(A_CAP, 4'h1, 32'h0000_0002);
    bus_read("cap_w1c", A_CAP, 32'h0);
    step(1);
    check("irq_clr", {31'h0, irq_o}, 32'h0);

    btn_i[0] = 1'b1;
    step(19);
    bus_read("cap_unmasked", A_CAP, 32'h1);
    step(2);
    check("irq_masked_off", {31'h0, irq_o}, 32'h0);

    btn_i[2] = 1'b1;
    step(18);
    bus_write(A_CAP, 4'h1, 32'h0000_0004);
    bus_read("cap_collide", A_CAP, 32'h5);
    bus_write(A_CAP, 4'h1, 32'h0000_0004);
    bus_read("cap_clr2", A_CAP, 32'h1);

    bus_write(A_CNT, 4'hF, 32'hFFFF_FFFE);
    bus_read("cnt_load", A_CNT, 32'hFFFF_FFFE);
    step(1);
    bus_read("cnt_inc", A_CNT, 32'hFFFF_FFFF);
    step(1);
    bus_read("cnt_wrap", A_CNT, 32'h0);
    bus_write(A_CNT, 4'b0001, 32'hAAAA_AA55);
    bus_read("cnt_byte", A_CNT, 32'h0000_0055);

    bus_read("rd_0x18", 32'hFFFF_0018, 32'h0);
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr_in = A_SEG;
    #1;
    check("rd_ce0", bus.data_o, 32'h0);
    bus_write(32'hFFFE_0000, 4'hF, 32'hFFFF_FFFF);
    check("oor_seg", seg_data_o, 32'h0000_5678);
    bus_read("oor_rd", 32'hFFFE_0000, 32'h0);
    bus_write(A_SW, 4'hF, 32'h0000_FFFF);
    bus_read("sw_ro", A_SW, 32'h0000_0008);
    bus_write(A_MASK, 4'hF, 32'hFFFF_FFFF);
    bus_read("mask_upper", A_MASK, 32'h0000_000F);
    step(1);
    check("irq_mask_on", {31'h0, irq_o}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_resp.md
# mmio_resp

Memory-mapped peripheral responder on the CPU data bus (`ce/we/addr/sel/data`), the target-side counterpart to the CPU's bus initiator port, decoded alongside `dmem`. It holds a CPU-writable display word that feeds `seg7` and exposes debounced board switches and buttons. It also provides sticky button-edge capture with an interrupt output for `int_i`, and a free-running cycle counter.

## Interface
- `BASE`, 32'hFFFF_0000: region base; decode on `addr_in[31:5] == BASE[31:5]`.
- `DB_CYCLES`, 16: stable-sample count required before a debounced bit changes (≥2).
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `ce` in 1: bus access strobe.
- `we` in 1: 1 = write, 0 = read.
- `addr_in` in 32: byte address; bits [1:0] ignored.
- `sel` in 4: byte enables; `sel[i]` enables `data_i[8i+7:8i]`.
- `data_i` in 32: write data.
- `data_o` out 32: read data.
- `sw_i` in 16: raw switches, asynchronous.
- `btn_i` in 4: raw buttons, asynchronous, active-high.
- `seg_data_o` out 32: display word to `seg7`.
- `irq_o` out 1: level interrupt.

## Operation
- Hit = `ce` & region match. Register index = `addr_in[4:2]`.
- Register map (offsets):
  - 0x00 SEG, RW, 32b. Drives `seg_data_o`.
  - 0x04 SW, RO. Returns {16'b0, debounced sw}.
  - 0x08 CAP, RW1C. Returns {28'b0, cap[3:0]}. Writing 1 to an enabled bit clears it.
  - 0x0C MASK, RW. Bits [3:0] are used; upper bits read 0.
  - 0x10 CNT, RW. Free-running counter; a write loads the enabled bytes.
  - 0x14–0x1C: read 0, writes ignored.
- Writes apply at the rising edge when hit & `we`, per `sel` byte. Writes to RO registers are ignored.
- Reads: `data_o` is combinational. It equals the register value when hit & !`we`, otherwise 32'h0.
- Input path:
  - Each `sw_i`/`btn_i` bit passes through a 2-flop synchronizer, then a per-bit debouncer.
  - The debouncer counter resets whenever the synchronized bit equals the stable bit.
  - The counter increments while the two differ. At count DB_CYCLES−1 the stable bit takes the new value and the counter resets.
- Capture:
  - `cap[i]` sets when debounced `btn[i]` goes 0→1, detected against a one-cycle-delayed copy.
  - A set and a W1C clear on the same edge: set wins.
- `irq_o` is registered as |(cap & mask[3:0]).
- CNT increments by 1 every cycle and wraps 32'hFFFF_FFFF→0. A write edge loads the written bytes instead of incrementing. Bytes not selected keep their current value (no increment that cycle).

## Timing
- Reset (`rst`=0, asynchronous) sets:
  - SEG = 0, MASK = 0, CAP = 0, CNT = 0, `irq_o` = 0.
  - Synchronizers and debounced state = 0; debounce counters = 0.
  - `seg_data_o` = 0. `data_o` is 0 unless a read hit is presented.
- Reset deassertion mid-access: there is no partial state, and the first edge after release behaves normally.
- A write is visible to a read in the next cycle. `seg_data_o` updates at the same edge as the write.
- Input latency from a raw change held stable: 2 synchronizer cycles + DB_CYCLES cycles to the debounced bit, +1 cycle to `cap`, +1 cycle to `irq_o`.
- Glitches shorter than DB_CYCLES synchronized cycles never reach the debounced bit.
- MASK or CAP write → `irq_o` responds one cycle later.
- Zero wait states: every hit completes in its own cycle. No stall output.

## Test plan
- Reset/SEG: assert `rst`=0 mid-sim and check all outputs are 0. Write 32'h1234_5678 with `sel`=4'b0011 after SEG = 0 → SEG reads 32'h0000_5678 and `seg_data_o` matches from that edge.
- Debounce, DB_CYCLES=16:
  - Toggle `sw_i[3]` for 10 cycles → SW reads 0.
  - Hold `sw_i[3]` high → SW reads 32'h0000_0008 exactly 18 cycles after the change.
- Capture/IRQ:
  - MASK = 4'b0010, hold `btn_i[1]` high → CAP = 4'b0010 and `irq_o` = 1 one cycle later.
  - Write CAP 4'b0010 → CAP = 0 and `irq_o` = 0.
  - Rising edge of `btn_i[0]` with bit 0 masked off → CAP bit 0 = 1, `irq_o` stays 0.
- Set/clear collision: align a W1C of CAP bit 2 with a debounced rise on `btn[2]` → CAP bit 2 remains 1.
- Counter:
  - Write CNT 32'hFFFF_FFFE → read 1 cycle later returns 32'hFFFF_FFFF, and the next read returns 0.
  - Read 0x18 → 0. Read with `ce`=0 → 0. Access with address outside BASE → no register change.
